// File: rtl/led_evt_pkg.sv
// Shared definitions for the LED event scheduler.
//   state_t    : scheduler FSM states
//   COL_*      : colour index of a sweep step (step / LED_COUNT)
//   LED_COUNT  : LEDs per colour bank
//   GRANT_W    : width of the pad index carried on grant_id
//   next_idx() : modular "base + off" over a pad count, used by the arbiter and the rr pointer
package led_evt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int COL_B     = 0;
    localparam int COL_G     = 1;
    localparam int COL_R     = 2;
    localparam int LED_COUNT = 4;
    localparam int GRANT_W   = 3;

    // base < n and off < n, so one conditional subtract is enough to wrap.
    function automatic logic [GRANT_W-1:0] next_idx(input logic [GRANT_W-1:0] base,
                                                    input int off, input int n);
        int s;
        s = int'(base) + off;
        if (s >= n) s = s - n;
        return GRANT_W'(s);
    endfunction

endpackage

// File: rtl/led_event_scheduler_if.sv
// Button/tick inputs and LED/status outputs of the LED event scheduler.
//   master : drives btn and tick, observes the LED bank and status
//   slave  : the scheduler side
//   tick      step enable pulse
//   btn       button levels, synchronous to clk
//   led_r/g/b one-hot sweep outputs
//   busy      high in PLAY or GAP
//   grant_id  pad owning the bank
//   done      sweep completed normally (1 clk)
//   abort     sweep cut short by a release (1 clk)
interface led_event_scheduler_if #(
    parameter int NUM_PADS = 4
);
    import led_evt_pkg::*;

    logic                 tick;
    logic [NUM_PADS-1:0]  btn;
    logic [LED_COUNT-1:0] led_r;
    logic [LED_COUNT-1:0] led_g;
    logic [LED_COUNT-1:0] led_b;
    logic                 busy;
    logic [GRANT_W-1:0]   grant_id;
    logic                 done;
    logic                 abort;

    modport master (
        output tick, btn,
        input  led_r, led_g, led_b, busy, grant_id, done, abort
    );

    modport slave (
        input  tick, btn,
        output led_r, led_g, led_b, busy, grant_id, done, abort
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req       : one request bit per pad
//   ptr       : highest-priority pad index
//   gnt_valid : at least one request is set
//   gnt_idx   : first set request at or after ptr, wrapping
module rr_arbiter
    import led_evt_pkg::*;
#(
    parameter int NUM_PADS = 4
) (
    input  logic [NUM_PADS-1:0] req,
    input  logic [GRANT_W-1:0]  ptr,
    output logic                gnt_valid,
    output logic [GRANT_W-1:0]  gnt_idx
);

    logic [NUM_PADS-1:0] rot;

    always_comb begin
        // rot[j] is req[(ptr + j) mod NUM_PADS]; the lowest set j is the winner.
        rot       = NUM_PADS'({req, req} >> ptr);
        gnt_valid = |rot;
        gnt_idx   = '0;
        for (int j = NUM_PADS - 1; j >= 0; j--) begin
            if (rot[j]) gnt_idx = next_idx(ptr, j, NUM_PADS);
        end
    end

endmodule

// File: rtl/led_event_scheduler.sv
// Shares one 4-LED RGB bank between NUM_PADS buttons. Each rising button edge
// queues one sweep for that pad; a round-robin arbiter grants the bank, the
// granted pad plays a one-hot sweep (blue 1..4, green 1..4, red 1..4) and a
// blank gap follows before the next grant.
//   clk  : system clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : slave side of led_event_scheduler_if (btn/tick in, LEDs and status out)
module led_event_scheduler
    import led_evt_pkg::*;
#(
    parameter int NUM_PADS  = 4,
    parameter int STEPS     = 12,
    parameter int GAP_TICKS = 2,
    parameter int HOLD_MODE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    led_event_scheduler_if.slave  bus
);

    localparam logic [3:0] STEP_LAST = 4'(STEPS - 1);
    localparam logic [7:0] GAP_LAST  = 8'(GAP_TICKS - 1);

    state_t              state, state_nx;
    logic [NUM_PADS-1:0] btn_q;
    logic [NUM_PADS-1:0] pending;
    logic [NUM_PADS-1:0] rise;
    logic [NUM_PADS-1:0] clr_mask;
    logic [GRANT_W-1:0]  ptr_q;
    logic [GRANT_W-1:0]  grant_q;
    logic [3:0]          step;
    logic [7:0]          gcnt;
    logic                entry_q;

    logic                arb_valid;
    logic [GRANT_W-1:0]  arb_idx;
    logic                grant_fire;
    logic                held;
    logic                released;
    logic                step_tick;
    logic                play_last;
    logic                gap_end;

    rr_arbiter #(
        .NUM_PADS (NUM_PADS)
    ) u_arb (
        .req       (pending),
        .ptr       (ptr_q),
        .gnt_valid (arb_valid),
        .gnt_idx   (arb_idx)
    );

    always_comb begin
        rise       = bus.btn & ~btn_q;
        grant_fire = (state == IDLE) && arb_valid;
        clr_mask   = '0;
        held       = 1'b0;
        for (int i = 0; i < NUM_PADS; i++) begin
            clr_mask[i] = grant_fire && (arb_idx == GRANT_W'(i));
            if (grant_q == GRANT_W'(i)) held = bus.btn[i];
        end
        released  = (HOLD_MODE != 0) && (state == PLAY) && !held;
        // The first PLAY clk ignores tick so step 0 is shown for a full tick period.
        step_tick = bus.tick && !entry_q;
        play_last = (step == STEP_LAST);
        gap_end   = (GAP_TICKS == 0) ? 1'b1 : (bus.tick && (gcnt == GAP_LAST));
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic; a release takes priority over a tick.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (arb_valid) state_nx = PLAY;
            PLAY:    if (released || (step_tick && play_last)) state_nx = GAP;
            GAP:     if (gap_end) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decode registered state; only done/abort see the live tick/btn.
    always_comb begin
        bus.led_r = '0;
        bus.led_g = '0;
        bus.led_b = '0;
        if (state == PLAY) begin
            case (step[3:2])
                2'(COL_B): bus.led_b[step[1:0]] = 1'b1;
                2'(COL_G): bus.led_g[step[1:0]] = 1'b1;
                2'(COL_R): bus.led_r[step[1:0]] = 1'b1;
                default:   ;
            endcase
        end
        bus.busy     = (state != IDLE);
        bus.grant_id = grant_q;
        bus.done     = (state == PLAY) && !released && step_tick && play_last;
        bus.abort    = released;
    end

    // Edge detect, pending queue, rr pointer and step/gap counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_q   <= '0;
            pending <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
            step    <= '0;
            gcnt    <= '0;
            entry_q <= 1'b0;
        end else begin
            btn_q   <= bus.btn;
            // A new edge on the pad being granted this clk re-queues it.
            pending <= (pending & ~clr_mask) | rise;
            entry_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        grant_q <= arb_idx;
                        ptr_q   <= next_idx(arb_idx, 1, NUM_PADS);
                        step    <= '0;
                        entry_q <= 1'b1;
                    end
                end
                PLAY: begin
                    gcnt <= '0;
                    if (!released && step_tick && !play_last) step <= step + 4'd1;
                end
                GAP: begin
                    if (bus.tick) gcnt <= gcnt + 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_led_event_scheduler.sv
// Bench for led_event_scheduler: two builds (hold/gap=2 and free-run/gap=0)
// share one stimulus stream; a behavioural model per build is checked every
// clk, and directed scenarios pin literal values.
module tb_led_event_scheduler;
    import led_evt_pkg::*;

    localparam int NP    = 4;
    localparam int STEPS = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NP-1:0] btn = '0;
    logic          tick = 1'b0;

    always #5 clk = ~clk;

    led_event_scheduler_if #(.NUM_PADS(NP)) bus0 ();
    led_event_scheduler_if #(.NUM_PADS(NP)) bus1 ();

    assign bus0.btn  = btn;
    assign bus0.tick = tick;
    assign bus1.btn  = btn;
    assign bus1.tick = tick;

    led_event_scheduler #(.NUM_PADS(NP), .STEPS(STEPS), .GAP_TICKS(2), .HOLD_MODE(1)) dut0 (
        .clk (clk), .rst (rst), .bus (bus0)
    );
    led_event_scheduler #(.NUM_PADS(NP), .STEPS(STEPS), .GAP_TICKS(0), .HOLD_MODE(0)) dut1 (
        .clk (clk), .rst (rst), .bus (bus1)
    );

    logic [17:0] out0, out1;
    assign out0 = {bus0.led_r, bus0.led_g, bus0.led_b, bus0.busy, bus0.grant_id, bus0.done, bus0.abort};
    assign out1 = {bus1.led_r, bus1.led_g, bus1.led_b, bus1.busy, bus1.grant_id, bus1.done, bus1.abort};

    int n_chk  = 0;
    int n_pass = 0;
    int dones0 = 0;
    int dones1 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // ph: 0 idle, 1 sweeping, 2 blank gap. pos: sweep position 0..STEPS-1.
    typedef struct packed {
        logic [NP-1:0] bq;
        logic [NP-1:0] pend;
        int            ptr;
        int            gid;
        int            ph;
        int            pos;
        int            gleft;
        logic          fresh;
    } mdl_t;

    mdl_t m0, m1;

    function automatic logic [17:0] mdl_out(input mdl_t m, input logic [NP-1:0] b,
                                            input logic t, input logic hold);
        logic [11:0] lit;
        logic        rel, dn;
        lit = (m.ph == 1) ? (12'd1 << m.pos) : 12'd0;
        rel = hold && (m.ph == 1) && !(1'(b >> m.gid));
        dn  = (m.ph == 1) && !rel && t && !m.fresh && (m.pos == STEPS - 1);
        return {lit, 1'(m.ph != 0), 3'(m.gid), dn, rel};
    endfunction

    function automatic mdl_t mdl_next(input mdl_t mi, input logic [NP-1:0] b, input logic t,
                                      input logic hold, input int gap);
        mdl_t          m;
        logic [NP-1:0] rise;
        logic          rel;
        int            c;
        m    = mi;
        rise = b & ~m.bq;
        rel  = hold && (m.ph == 1) && !(1'(b >> m.gid));
        m.bq = b;
        if (m.ph == 0) begin
            for (int k = 0; k < NP; k++) begin
                c = (m.ptr + k) % NP;
                if (m.ph == 0 && m.pend[c]) begin
                    m.gid = c; m.pend[c] = 1'b0; m.ptr = (c + 1) % NP;
                    m.pos = 0; m.fresh = 1'b1; m.ph = 1;
                end
            end
        end else if (m.ph == 1) begin
            if (rel) begin
                m.ph = 2; m.gleft = gap;
            end else if (t && !m.fresh) begin
                if (m.pos == STEPS - 1) begin m.ph = 2; m.gleft = gap; end
                else m.pos = m.pos + 1;
            end
            m.fresh = 1'b0;
        end else begin
            if (m.gleft == 0) m.ph = 0;
            else if (t) begin
                m.gleft = m.gleft - 1;
                if (m.gleft == 0) m.ph = 0;
            end
        end
        m.pend = m.pend | rise;
        return m;
    endfunction

    // Compare process: every clk, both builds against their models.
    always @(negedge clk) begin
        if (rst) begin
            m0 = '0;
            m1 = '0;
            chk("rst_out0", 32'(out0), 32'd0);
            chk("rst_out1", 32'(out1), 32'd0);
        end else begin
            chk("model0", 32'(out0), 32'(mdl_out(m0, btn, tick, 1'b1)));
            chk("model1", 32'(out1), 32'(mdl_out(m1, btn, tick, 1'b0)));
            m0 = mdl_next(m0, btn, tick, 1'b1, 2);
            m1 = mdl_next(m1, btn, tick, 1'b0, 0);
        end
    end

    // ---------------- stimulus ----------------
    logic [11:0] sweep_tab [12] = '{12'h001, 12'h002, 12'h004, 12'h008,
                                    12'h010, 12'h020, 12'h040, 12'h080,
                                    12'h100, 12'h200, 12'h400, 12'h800};

    // Applies inputs just after a rising edge and returns 2 ns later.
    task automatic drive(input logic [NP-1:0] b, input logic t);
        @(posedge clk);
        #1;
        btn  = b;
        tick = t;
        #2;
    endtask

    task automatic run_ticks(input logic [NP-1:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            drive(b, 1'b1);
            if (bus0.done) dones0++;
            if (bus1.done) dones1++;
            drive(b, 1'b0);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1; btn = '0; tick = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [NP-1:0] nb;

    initial begin
        // 1: reset values, then a full held sweep on pad0
        repeat (3) @(posedge clk);
        #3;
        chk("reset_leds", 32'({bus0.led_r, bus0.led_g, bus0.led_b}), 32'd0);
        chk("reset_status", 32'({bus0.busy, bus0.grant_id, bus0.done, bus0.abort}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(4'b0001, 1'b0);
        drive(4'b0001, 1'b0);
        chk("t1_not_yet", 32'(bus0.busy), 32'd0);
        drive(4'b0001, 1'b0);
        chk("t1_grant", 32'({bus0.busy, bus0.grant_id}), 32'h8);
        for (int k = 0; k < 12; k++) begin
            chk("t1_sweep", 32'({bus0.led_r, bus0.led_g, bus0.led_b}), 32'(sweep_tab[k]));
            drive(4'b0001, 1'b1);
            chk("t1_done", 32'(bus0.done), (k == 11) ? 32'd1 : 32'd0);
            drive(4'b0001, 1'b0);
        end
        chk("t1_gap", 32'({bus0.led_r, bus0.led_g, bus0.led_b, bus0.busy}), 32'd1);
        run_ticks(4'b0001, 1);
        chk("t1_gap_busy", 32'(bus0.busy), 32'd1);
        run_ticks(4'b0001, 1);
        chk("t1_idle", 32'(bus0.busy), 32'd0);
        drive(4'b0000, 1'b0);

        // 2: pads 1 and 3 together from ptr=0
        do_reset();
        dones0 = 0;
        drive(4'b1010, 1'b0);
        drive(4'b1010, 1'b0);
        drive(4'b1010, 1'b0);
        chk("t2_first", 32'({bus0.grant_id, bus0.led_b}), 32'h11);
        run_ticks(4'b1010, 12);
        run_ticks(4'b1010, 2);
        drive(4'b1010, 1'b0);
        chk("t2_second", 32'({bus0.busy, bus0.grant_id}), 32'hB);
        run_ticks(4'b1010, 12);
        chk("t2_dones", 32'(dones0), 32'd2);
        drive(4'b0000, 1'b0);
        run_ticks(4'b0000, 2);

        // 3: release pad2 at step 5
        do_reset();
        dones0 = 0;
        drive(4'b0100, 1'b0);
        drive(4'b0100, 1'b0);
        drive(4'b0100, 1'b0);
        run_ticks(4'b0100, 5);
        chk("t3_step5", 32'({bus0.led_r, bus0.led_g, bus0.led_b}), 32'h020);
        drive(4'b0000, 1'b0);
        chk("t3_abort", 32'({bus0.done, bus0.abort}), 32'd1);
        drive(4'b0000, 1'b0);
        chk("t3_gap", 32'({bus0.led_r, bus0.led_g, bus0.led_b, bus0.busy, bus0.done, bus0.abort}), 32'd4);
        run_ticks(4'b0000, 2);
        chk("t3_idle", 32'({bus0.busy, dones0[3:0]}), 32'd0);

        // 4: repeat presses during play (free-running build)
        do_reset();
        dones1 = 0;
        drive(4'b0001, 1'b0);
        drive(4'b0001, 1'b0);
        drive(4'b0001, 1'b0);
        run_ticks(4'b0001, 3);
        repeat (10) begin
            drive(4'b0000, 1'b0);
            drive(4'b0001, 1'b0);
        end
        run_ticks(4'b0001, 9);
        chk("t4_first_done", 32'(dones1), 32'd1);
        chk("t4_gap", 32'({bus1.led_r, bus1.led_g, bus1.led_b, bus1.busy}), 32'd1);
        drive(4'b0001, 1'b0);
        chk("t4_gap_1clk", 32'(bus1.busy), 32'd0);
        drive(4'b0001, 1'b0);
        chk("t4_replay", 32'({bus1.busy, bus1.grant_id, bus1.led_b}), 32'h81);
        run_ticks(4'b0001, 12);
        chk("t4_second_done", 32'(dones1), 32'd2);
        repeat (3) drive(4'b0001, 1'b0);
        chk("t4_no_third", 32'(bus1.busy), 32'd0);
        drive(4'b0000, 1'b0);

        // 5: asynchronous reset at step 7 with pad1 queued
        do_reset();
        drive(4'b0001, 1'b0);
        drive(4'b0001, 1'b0);
        drive(4'b0001, 1'b0);
        run_ticks(4'b0001, 7);
        chk("t5_step7", 32'({bus0.led_r, bus0.led_g, bus0.led_b}), 32'h080);
        drive(4'b0011, 1'b0);
        drive(4'b0011, 1'b0);
        rst = 1'b1;
        btn = '0;
        #1;
        chk("t5_async0", 32'(out0), 32'd0);
        chk("t5_async1", 32'(out1), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_ticks(4'b0000, 10);
        chk("t5_quiet", 32'({bus0.busy, bus1.busy}), 32'd0);

        // 6: tick on the PLAY-entry clk is ignored
        do_reset();
        drive(4'b0001, 1'b0);
        drive(4'b0001, 1'b0);
        drive(4'b0001, 1'b1);
        drive(4'b0001, 1'b0);
        chk("t6_step0", 32'({bus0.led_r, bus0.led_g, bus0.led_b}), 32'h001);
        drive(4'b0001, 1'b1);
        drive(4'b0001, 1'b0);
        chk("t6_step1", 32'({bus0.led_r, bus0.led_g, bus0.led_b}), 32'h002);
        drive(4'b0000, 1'b0);
        run_ticks(4'b0000, 14);

        // Random traffic, including occasional resets
        for (int c = 0; c < 4000; c++) begin
            nb = btn;
            for (int i = 0; i < NP; i++) begin
                if ($urandom_range(0, 39) == 0) nb[i] = ~nb[i];
            end
            @(posedge clk);
            #1;
            btn  = nb;
            tick = ($urandom_range(0, 2) == 0);
            rst  = ($urandom_range(0, 599) == 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
